// File: rtl/tri_bus_share_ctrl.sv
// rtl/tri_bus_share_ctrl.sv - round-robin owner control for a multi-channel shared tristate bus
module tri_bus_share_ctrl #(
    parameter int NCH      = 4,
    parameter int WIDTH    = 8,
    parameter int TURN     = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] inp,
    output logic [NCH-1:0]       gnt,
    output logic [NCH-1:0]       enb,
    output tri   [WIDTH-1:0]     z,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

    localparam int PW = $clog2(NCH);
    localparam int TW = 4;
    localparam int HW = 16;
    localparam logic [HW-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : HW'(HOLD_MAX - 1);
    localparam logic [TW-1:0] TURN_LAST = (TURN == 0) ? '0 : TW'(TURN - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   own_q, own_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   turn_q, turn_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]   rel_ptr;
    logic [PW:0]     pick_cur;
    logic [PW:0]     pick_rel;
    logic            others;
    logic            release_now;

    // Returns {found, index} of the first set bit at or above p, wrapping to 0.
    function automatic logic [PW:0] rr_pick(input logic [NCH-1:0] r, input logic [PW-1:0] p);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NCH;
            if (r[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        own_d       = own_q;
        hold_d      = hold_q;
        turn_d      = turn_q;
        gnt_d       = gnt_q;
        rel_ptr     = PW'((int'(own_q) + 1) % NCH);
        pick_cur    = rr_pick(req, ptr_q);
        pick_rel    = rr_pick(req, rel_ptr);
        others      = |(req & ~gnt_q);
        // >= rather than == so a late challenger still forces release after a long solo tenure
        release_now = !req[own_q] || ((HOLD_MAX != 0) && (hold_q >= HOLD_LAST) && others);

        case (state_q)
            S_IDLE: begin
                if (pick_cur[PW]) begin
                    state_d = S_DRIVE;
                    own_d   = pick_cur[PW-1:0];
                    gnt_d   = NCH'(1) << pick_cur[PW-1:0];
                    hold_d  = '0;
                end
            end
            S_DRIVE: begin
                if (release_now) begin
                    ptr_d  = rel_ptr;
                    gnt_d  = '0;
                    hold_d = '0;
                    if (TURN != 0) begin
                        state_d = S_TURN;
                        turn_d  = '0;
                    end else if (pick_rel[PW]) begin
                        own_d = pick_rel[PW-1:0];
                        gnt_d = NCH'(1) << pick_rel[PW-1:0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_TURN: begin
                if (turn_q >= TURN_LAST) begin
                    if (pick_cur[PW]) begin
                        state_d = S_DRIVE;
                        own_d   = pick_cur[PW-1:0];
                        gnt_d   = NCH'(1) << pick_cur[PW-1:0];
                        hold_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gnt  = gnt_q;
    assign enb  = gnt_q;
    assign busy = (state_q != S_IDLE);

    for (genvar i = 0; i < NCH; i++) begin : g_drv
        assign z = enb[i] ? inp[i*WIDTH +: WIDTH] : {WIDTH{1'bz}};
    end

endmodule

// File: tb/tb_tri_bus_share_ctrl.sv
// tb/tb_tri_bus_share_ctrl.sv - randomized model-checked bench for tri_bus_share_ctrl
module tb_tri_bus_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req  [2];
    logic [31:0] inp  [2];
    logic [3:0]  gnt  [2];
    logic [3:0]  enb  [2];
    logic        busy [2];
    wire  [7:0]  z_a;
    wire  [7:0]  z_b;

    int vectors     = 0;
    int miscompares = 0;

    int m_own  [2] = '{-1, -1};
    int m_ptr  [2] = '{0, 0};
    int m_ten  [2] = '{0, 0};
    int m_dead [2] = '{0, 0};
    int m_turn [2] = '{1, 0};
    int m_hmax [2] = '{8, 3};

    always #5 clk = ~clk;

    tri_bus_share_ctrl #(.NCH(4), .WIDTH(8), .TURN(1), .HOLD_MAX(8)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .inp(inp[0]),
        .gnt(gnt[0]), .enb(enb[0]), .z(z_a), .busy(busy[0]));

    tri_bus_share_ctrl #(.NCH(4), .WIDTH(8), .TURN(0), .HOLD_MAX(3)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .inp(inp[1]),
        .gnt(gnt[1]), .enb(enb[1]), .z(z_b), .busy(busy[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Model: who owns the bus, how long they have held it, and dead cycles still owed.
    task automatic step(input int k, input logic [3:0] r);
        int w;
        logic [3:0] rivals;
        if (m_own[k] >= 0) begin
            rivals = r & ~(4'b0001 << m_own[k]);
            if (!r[m_own[k]] || (m_hmax[k] != 0 && m_ten[k] >= m_hmax[k] && rivals != 0)) begin
                m_ptr[k] = (m_own[k] + 1) % 4;
                m_own[k] = -1;
                if (m_turn[k] > 0) begin
                    m_dead[k] = m_turn[k];
                end else begin
                    w = pick(r, m_ptr[k]);
                    if (w >= 0) begin m_own[k] = w; m_ten[k] = 1; end
                end
            end else if (m_ten[k] < 100000) begin
                m_ten[k]++;
            end
        end else if (m_dead[k] > 0) begin
            m_dead[k]--;
            if (m_dead[k] == 0) begin
                w = pick(r, m_ptr[k]);
                if (w >= 0) begin m_own[k] = w; m_ten[k] = 1; end
            end
        end else begin
            w = pick(r, m_ptr[k]);
            if (w >= 0) begin m_own[k] = w; m_ten[k] = 1; end
        end
    endtask

    always @(negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_ptr[k] = 0; m_ten[k] = 0; m_dead[k] = 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            step(0, req[0]);
            step(1, req[1]);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [3:0] eg;
            logic       eb;
            logic [7:0] zv;
            eg = (rst_n && m_own[k] >= 0) ? (4'b0001 << m_own[k]) : 4'b0000;
            eb = rst_n && (m_own[k] >= 0 || m_dead[k] > 0);
            zv = (k == 0) ? z_a : z_b;
            check($sformatf("gnt%0d", k), 32'(gnt[k]), 32'(eg));
            check($sformatf("enb%0d", k), 32'(enb[k]), 32'(eg));
            check($sformatf("busy%0d", k), 32'(busy[k]), 32'(eb));
            check($sformatf("onehot%0d", k), 32'($countones(enb[k]) <= 1), 32'd1);
            if (rst_n && m_own[k] >= 0)
                check($sformatf("z%0d", k), 32'(zv), 32'(inp[k][m_own[k]*8 +: 8]));
        end
    end

    initial begin
        logic [3:0] exp_g;
        rst_n  = 1'b0;
        req[0] = 4'hF;
        req[1] = 4'h0;
        inp[0] = 32'h44332211;
        inp[1] = 32'hDDCCBBAA;
        #1;
        check("reset_gnt", 32'(gnt[0]), 32'h0);
        check("reset_enb", 32'(enb[0]), 32'h0);
        check("reset_busy", 32'(busy[0]), 32'h0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant full request: 8-cycle tenures, one dead cycle, owners 0,1,2,3,0.
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            exp_g = (t % 9 == 8) ? 4'b0000 : (4'b0001 << ((t / 9) % 4));
            check("rotation", 32'(gnt[0]), 32'(exp_g));
            check("model_rotation", 32'((m_own[0] >= 0) ? (4'b0001 << m_own[0]) : 4'b0000), 32'(exp_g));
        end

        req[0] = 4'h0;
        repeat (3) @(negedge clk);
        check("idle_after_drop", 32'(busy[0]), 32'h0);

        inp[0] = {8'h44, 8'h33, 8'hA5, 8'h11};
        req[0] = 4'b0010;
        @(negedge clk);
        check("single_gnt", 32'(gnt[0]), 32'h2);
        check("single_z", 32'(z_a), 32'hA5);

        req[0] = 4'b0101;
        @(negedge clk);
        check("prio_dead_enb", 32'(enb[0]), 32'h0);
        check("prio_dead_busy", 32'(busy[0]), 32'h1);
        @(negedge clk);
        check("prio_ch2", 32'(gnt[0]), 32'h4);
        check("prio_ch2_z", 32'(z_a), 32'h33);
        req[0] = 4'b0001;
        @(negedge clk);
        check("prio_dead2", 32'(enb[0]), 32'h0);
        @(negedge clk);
        check("prio_ch0", 32'(gnt[0]), 32'h1);

        req[0] = 4'b0000;
        @(negedge clk);
        check("drop_enb", 32'(enb[0]), 32'h0);
        check("drop_busy", 32'(busy[0]), 32'h1);
        @(negedge clk);
        check("drop_idle", 32'(busy[0]), 32'h0);

        req[0] = 4'b0100;
        @(negedge clk);
        check("pre_async", 32'(gnt[0]), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("async_enb", 32'(enb[0]), 32'h0);
        check("async_gnt", 32'(gnt[0]), 32'h0);
        check("async_busy", 32'(busy[0]), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        req[0] = 4'b1000;
        @(negedge clk);
        check("post_reset_ch3", 32'(gnt[0]), 32'h8);

        req[0] = 4'b0000;
        req[1] = 4'b0011;
        @(negedge clk);
        check("t0_ch0", 32'(gnt[1]), 32'h1);
        req[1] = 4'b0010;
        @(negedge clk);
        check("t0_handoff", 32'(enb[1]), 32'h2);
        check("t0_z", 32'(z_b), 32'hBB);
        req[1] = 4'b0000;
        @(negedge clk);
        check("t0_idle", 32'(busy[1]), 32'h0);

        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 2; k++) begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 7) == 0) req[k][b] = ~req[k][b];
                inp[k] = $urandom;
            end
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
